// File: rtl/onchip_ram_dp.sv
// onchip_ram_dp
//   True-dual-port on-chip RAM with two Avalon-MM slave ports (s1, s2)
//   sharing one clock. The array is inferred as a plain register array, split
//   into one array per byte lane so that byte-enable writes map cleanly.
//
//   Parameters
//     DATA_W     word width in bits (multiple of 8)
//     ADDR_W     word-address width, DEPTH = 2**ADDR_W
//     OUT_REG    0: read latency 1, 1: extra output register, latency 2
//     INIT_CLEAR 1: zero the whole array after reset before accepting traffic
//
//   Ports
//     clk, reset_n                 clock, asynchronous active-low reset
//     sN_address/chipselect/read/write/byteenable/writedata   request, port N
//     sN_readdata/readdatavalid    read response, port N
//     sN_waitrequest               request not accepted this cycle, port N
//     init_done                    clear sequence complete, array usable
//     parity_err                   sticky parity error flag
//
//   Optional feature: define ONCHIP_RAM_PARITY_EN to store one even-parity
//   bit per byte and check it on every read response. Without the macro
//   there is no parity storage and parity_err is tied low.

module onchip_ram_dp #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,

  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest,

  output logic                init_done,
  output logic                parity_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;
`ifdef ONCHIP_RAM_PARITY_EN
  localparam int unsigned LANE_W = 9;
  localparam int unsigned MEM_W  = DATA_W + NB;
`else
  localparam int unsigned LANE_W = 8;
  localparam int unsigned MEM_W  = DATA_W;
`endif

  typedef enum logic {CLEAR, READY} state_e;
  localparam state_e RST_STATE = (INIT_CLEAR != 0) ? CLEAR : READY;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              ready_q;
  logic              clearing;

  // Port signals gathered into index-0 = s1, index-1 = s2.
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][NB-1:0]     be;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0]             cs, rd, wr;
  logic [1:0]             wait_req, wr_acc, rd_acc;
  logic                   collide;

  logic [1:0][MEM_W-1:0]  rd_word;
  logic [1:0][MEM_W-1:0]  out_w;
  logic [1:0]             out_v;

  assign addr  = {s2_address, s1_address};
  assign be    = {s2_byteenable, s1_byteenable};
  assign wdata = {s2_writedata, s1_writedata};
  assign cs    = {s2_chipselect, s1_chipselect};
  assign rd    = {s2_read, s1_read};
  assign wr    = {s2_write, s1_write};

  // Same-address write collision: s1 wins, s2 is stalled and retries.
  assign collide     = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);
  assign wait_req[0] = ~ready_q;
  assign wait_req[1] = ~ready_q | collide;

  // A read with write also asserted performs only the write.
  assign wr_acc = cs & wr & ~wait_req;
  assign rd_acc = cs & rd & ~wr & ~wait_req;

  assign clearing = (state_q == CLEAR);

  // Control FSM: CLEAR walks every address once, then READY for good.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        READY:   ready_q <= 1'b1;
        default: state_q <= RST_STATE;
      endcase
    end
  end

  // Byte-lane storage. Reads are taken combinationally here and registered
  // in the port pipeline, so a read sees the array before this edge's writes.
  for (genvar l = 0; l < NB; l++) begin : g_lane
    logic [LANE_W-1:0] mem_q [DEPTH];
    logic [LANE_W-1:0] wl0, wl1;

`ifdef ONCHIP_RAM_PARITY_EN
    assign wl0 = {^wdata[0][8*l +: 8], wdata[0][8*l +: 8]};
    assign wl1 = {^wdata[1][8*l +: 8], wdata[1][8*l +: 8]};
`else
    assign wl0 = wdata[0][8*l +: 8];
    assign wl1 = wdata[1][8*l +: 8];
`endif

    // All-zero clear data carries even parity 0, so '0 is a valid word.
    always_ff @(posedge clk) begin
      if (clearing) begin
        mem_q[clr_cnt_q] <= '0;
      end else begin
        if (wr_acc[0] && be[0][l]) mem_q[addr[0]] <= wl0;
        if (wr_acc[1] && be[1][l]) mem_q[addr[1]] <= wl1;
      end
    end

    assign rd_word[0][8*l +: 8] = mem_q[addr[0]][7:0];
    assign rd_word[1][8*l +: 8] = mem_q[addr[1]][7:0];
`ifdef ONCHIP_RAM_PARITY_EN
    assign rd_word[0][DATA_W+l] = mem_q[addr[0]][8];
    assign rd_word[1][DATA_W+l] = mem_q[addr[1]][8];
`endif
  end

  // Per-port read pipeline; data registers only load on a valid beat so the
  // visible readdata holds between pulses.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [MEM_W-1:0] w1_q;
    logic             v1_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        w1_q <= '0;
        v1_q <= 1'b0;
      end else begin
        v1_q <= rd_acc[p];
        if (rd_acc[p]) w1_q <= rd_word[p];
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic [MEM_W-1:0] w2_q;
      logic             v2_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          w2_q <= '0;
          v2_q <= 1'b0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) w2_q <= w1_q;
        end
      end

      assign out_w[p] = w2_q;
      assign out_v[p] = v2_q;
    end else begin : g_noreg
      assign out_w[p] = w1_q;
      assign out_v[p] = v1_q;
    end
  end

  assign s1_readdata      = out_w[0][DATA_W-1:0];
  assign s2_readdata      = out_w[1][DATA_W-1:0];
  assign s1_readdatavalid = out_v[0];
  assign s2_readdatavalid = out_v[1];
  assign s1_waitrequest   = wait_req[0];
  assign s2_waitrequest   = wait_req[1];
  assign init_done        = ready_q;

`ifdef ONCHIP_RAM_PARITY_EN
  function automatic logic par_bad(input logic [MEM_W-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      bad = bad | (^w[8*i +: 8] ^ w[DATA_W+i]);
    end
    return bad;
  endfunction

  logic parity_err_q;

  // Checked on the response beat; sticky until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err_q <= 1'b0;
    end else if ((out_v[0] && par_bad(out_w[0])) || (out_v[1] && par_bad(out_w[1]))) begin
      parity_err_q <= 1'b1;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_onchip_ram_dp.sv
// Self-checking bench for onchip_ram_dp: directed scenarios followed by
// random dual-port traffic, all checked against an array/queue reference.
module tb_onchip_ram_dp;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned OREG  = 0;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LAT   = 1 + OREG;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_read, s1_write;
  logic          s2_chipselect, s2_read, s2_write;
  logic [3:0]    s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata;
  logic [DW-1:0] s1_readdata, s2_readdata;
  logic          s1_readdatavalid, s2_readdatavalid;
  logic          s1_waitrequest, s2_waitrequest;
  logic          init_done, parity_err;

  onchip_ram_dp #(
    .DATA_W(DW), .ADDR_W(AW), .OUT_REG(OREG), .INIT_CLEAR(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
    .s2_waitrequest(s2_waitrequest),
    .init_done(init_done), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } rd_t;

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  int unsigned   cyc, clr_cnt;
  logic          model_ready, exp_perr;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] last_rd [2];
  rd_t           q1[$];
  rd_t           q2[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic set_idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
  endtask

  task automatic drv1(input logic cs, input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [3:0] be, input logic [DW-1:0] d);
    s1_chipselect = cs; s1_read = r; s1_write = w; s1_address = a; s1_byteenable = be; s1_writedata = d;
  endtask

  task automatic drv2(input logic cs, input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [3:0] be, input logic [DW-1:0] d);
    s2_chipselect = cs; s2_read = r; s2_write = w; s2_address = a; s2_byteenable = be; s2_writedata = d;
  endtask

  task automatic check_port(input int unsigned p, input logic v, input logic [DW-1:0] d);
    logic ev;
    rd_t  e;
    ev = 1'b0;
    if (p == 1) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); ev = 1'b1; last_rd[0] = e.data; end
      chk("s1_readdatavalid", {31'b0, v}, {31'b0, ev});
      chk("s1_readdata", d, last_rd[0]);
    end else begin
      if (q2.size() > 0 && q2[0].due == cyc) begin e = q2.pop_front(); ev = 1'b1; last_rd[1] = e.data; end
      chk("s2_readdatavalid", {31'b0, v}, {31'b0, ev});
      chk("s2_readdata", d, last_rd[1]);
    end
  endtask

  // One clock of traffic: inputs are already driven; check handshakes,
  // update the reference at the edge, then check responses.
  task automatic step();
    logic col, w1, w2, wa1, wa2, ra1, ra2;
    #1;
    col = s1_chipselect && s1_write && s2_chipselect && s2_write && (s1_address == s2_address);
    w1  = !model_ready;
    w2  = !model_ready || col;
    chk("s1_waitrequest", {31'b0, s1_waitrequest}, {31'b0, w1});
    chk("s2_waitrequest", {31'b0, s2_waitrequest}, {31'b0, w2});
    chk("init_done", {31'b0, init_done}, {31'b0, model_ready});
    wa1 = s1_chipselect && s1_write && !w1;
    wa2 = s2_chipselect && s2_write && !w2;
    ra1 = s1_chipselect && s1_read && !s1_write && !w1;
    ra2 = s2_chipselect && s2_read && !s2_write && !w2;
    if (ra1) q1.push_back('{due: cyc + LAT, data: ref_mem[s1_address]});
    if (ra2) q2.push_back('{due: cyc + LAT, data: ref_mem[s2_address]});
    if (wa1) ref_mem[s1_address] = merge(ref_mem[s1_address], s1_writedata, s1_byteenable);
    if (wa2) ref_mem[s2_address] = merge(ref_mem[s2_address], s2_writedata, s2_byteenable);
    @(posedge clk);
    #1;
    cyc++;
    if (!model_ready) begin
      clr_cnt++;
      if (clr_cnt == DEPTH) model_ready = 1'b1;
    end
    check_port(1, s1_readdatavalid, s1_readdata);
    check_port(2, s2_readdatavalid, s2_readdata);
    chk("parity_err", {31'b0, parity_err}, {31'b0, exp_perr});
  endtask

  task automatic do_reset(input int unsigned hold);
    set_idle();
    reset_n = 1'b0;
    #3;
    chk("rst_s1_readdata", s1_readdata, '0);
    chk("rst_s2_readdata", s2_readdata, '0);
    chk("rst_s1_rdv", {31'b0, s1_readdatavalid}, '0);
    chk("rst_s2_rdv", {31'b0, s2_readdatavalid}, '0);
    chk("rst_s1_wait", {31'b0, s1_waitrequest}, 32'd1);
    chk("rst_s2_wait", {31'b0, s2_waitrequest}, 32'd1);
    chk("rst_init_done", {31'b0, init_done}, '0);
    chk("rst_parity_err", {31'b0, parity_err}, '0);
    repeat (hold) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0; clr_cnt = 0; model_ready = 1'b0; exp_perr = 1'b0;
    q1.delete(); q2.delete();
    last_rd[0] = '0; last_rd[1] = '0;
    foreach (ref_mem[i]) ref_mem[i] = '0;
  endtask

  task automatic idle_steps(input int unsigned n);
    set_idle();
    repeat (n) step();
  endtask

  initial begin
    set_idle();
    reset_n = 1'b1;
    #2;

    // Interrupted clear, then a full clear of exactly DEPTH cycles.
    do_reset(2);
    idle_steps(10);
    do_reset(2);
    idle_steps(DEPTH);
    chk("init_done_after_clear", {31'b0, init_done}, 32'd1);

    // Cleared word reads zero.
    drv1(1, 1, 0, 5, 4'h0, '0); step();
    idle_steps(LAT - 1);
    chk("clear_rd_valid", {31'b0, s1_readdatavalid}, 32'd1);
    chk("clear_rd_data", s1_readdata, 32'h0);

    // Byte-lane merge seen from the other port.
    set_idle(); drv1(1, 0, 1, 16, 4'hF, 32'hDEADBEEF); step();
    drv1(1, 0, 1, 16, 4'h1, 32'h000000AA); step();
    set_idle(); drv2(1, 1, 0, 16, 4'h0, '0); step();
    idle_steps(LAT - 1);
    chk("be_merge_valid", {31'b0, s2_readdatavalid}, 32'd1);
    chk("be_merge_data", s2_readdata, 32'hDEADBEAA);

    // Same-address write collision: s2 stalls, retries, ends up final.
    set_idle();
    drv1(1, 0, 1, 3, 4'hF, 32'h11111111);
    drv2(1, 0, 1, 3, 4'hF, 32'h22222222);
    #1;
    chk("collide_s2_wait", {31'b0, s2_waitrequest}, 32'd1);
    chk("collide_s1_go", {31'b0, s1_waitrequest}, 32'd0);
    step();
    drv1(0, 0, 0, 0, 4'h0, '0); step();
    set_idle(); drv1(1, 1, 0, 3, 4'h0, '0); step();
    idle_steps(LAT - 1);
    chk("collide_final", s1_readdata, 32'h22222222);

    // Mixed-port read-before-write.
    set_idle(); drv1(1, 0, 1, 7, 4'hF, 32'h3); step();
    drv1(1, 0, 1, 7, 4'hF, 32'h5); drv2(1, 1, 0, 7, 4'h0, '0); step();
    idle_steps(LAT - 1);
    chk("rbw_old", s2_readdata, 32'h3);
    drv2(1, 1, 0, 7, 4'h0, '0); step();
    idle_steps(LAT - 1);
    chk("rbw_new", s2_readdata, 32'h5);

    // Same-port write then read next cycle.
    set_idle(); drv1(1, 0, 1, 9, 4'hF, 32'hCAFEF00D); step();
    drv1(1, 1, 0, 9, 4'h0, '0); step();
    idle_steps(LAT - 1);
    chk("same_port_wr_rd", s1_readdata, 32'hCAFEF00D);

    // Read+write together performs only the write; be=0 write is a no-op.
    set_idle(); drv1(1, 1, 1, 10, 4'hF, 32'h12345678); step();
    idle_steps(LAT);
    chk("rdwr_no_valid", {31'b0, s1_readdatavalid}, 32'd0);
    drv1(1, 0, 1, 10, 4'h0, 32'hFFFFFFFF); step();
    drv1(1, 1, 0, 10, 4'h0, '0); step();
    idle_steps(LAT - 1);
    chk("be0_noop", s1_readdata, 32'h12345678);

    // Back-to-back pipelined reads.
    for (int i = 0; i < 4; i++) begin
      set_idle(); drv2(1, 0, 1, AW'(i), 4'hF, 32'hA0 + 32'(i)); step();
    end
    for (int i = 0; i < 4; i++) begin
      set_idle(); drv1(1, 1, 0, AW'(i), 4'h0, '0); step();
      if (i >= int'(LAT) - 1) begin
        chk("b2b_valid", {31'b0, s1_readdatavalid}, 32'd1);
        chk("b2b_data", s1_readdata, 32'hA0 + 32'(i - (int'(LAT) - 1)));
      end
    end
    idle_steps(LAT);

    // Random dual-port traffic, narrow address range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] a1, a2;
      a1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      drv1($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), a1, 4'($urandom), $urandom);
      drv2($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), a2, 4'($urandom), $urandom);
      step();
    end
    idle_steps(LAT + 1);

`ifdef ONCHIP_RAM_PARITY_EN
    // Corrupt one stored bit: data is returned as stored, the flag latches.
    set_idle(); drv1(1, 0, 1, 2, 4'hF, 32'h0F0F0F0F); step();
    idle_steps(1);
    dut.g_lane[0].mem_q[2][0] = ~dut.g_lane[0].mem_q[2][0];
    ref_mem[2] = ref_mem[2] ^ 32'h1;
    drv1(1, 1, 0, 2, 4'h0, '0); step();
    idle_steps(LAT - 1);
    exp_perr = 1'b1;
    idle_steps(1);
    chk("perr_set", {31'b0, parity_err}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drv2(1, 1, 0, AW'(i + 4), 4'h0, '0); step();
    end
    idle_steps(LAT);
    chk("perr_sticky", {31'b0, parity_err}, 32'd1);
    do_reset(1);
    idle_steps(DEPTH);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
